// File: rtl/pwm_pkg.sv
// -----------------------------------------------------------------------------
// pwm_pkg
// Constants and types shared between the audio PWM generator and the PWM
// receiver (pwm_demod).
//   PWM_FRAME   : slots per PWM frame (2**PWM_DUTY_W)
//   PWM_DUTY_W  : width of the duty value carried by one frame
//   pwm_state_e : receiver lock state
// -----------------------------------------------------------------------------
package pwm_pkg;

  localparam int PWM_DUTY_W = 5;
  localparam int PWM_FRAME  = 32;

  // HUNT: waiting for a frame-start rising edge (and reporting line-idle
  // timeouts). MEASURE: locked to a frame, accumulating high slots.
  typedef enum logic {
    HUNT    = 1'b0,
    MEASURE = 1'b1
  } pwm_state_e;

endpackage : pwm_pkg

// File: rtl/pwm_demod_if.sv
// -----------------------------------------------------------------------------
// pwm_demod_if
// Bundles the PWM line and the measurement results of the receiver.
//   pwm_in     : serial PWM line (asynchronous to the receiver clock)
//   duty_out   : last measured duty, held between updates
//   duty_valid : one-clk pulse when duty_out is updated
//   stuck_high : level, line high without frame structure
//   sync_err   : one-clk pulse on a rising edge inside a frame
// Modports:
//   master : the receiver (consumes the line, produces the results)
//   slave  : the environment (drives the line, observes the results)
// -----------------------------------------------------------------------------
interface pwm_demod_if
  import pwm_pkg::*;
#(
  parameter int DUTY_W = PWM_DUTY_W
);

  logic              pwm_in;
  logic [DUTY_W-1:0] duty_out;
  logic              duty_valid;
  logic              stuck_high;
  logic              sync_err;

  modport master (
    input  pwm_in,
    output duty_out,
    output duty_valid,
    output stuck_high,
    output sync_err
  );

  modport slave (
    output pwm_in,
    input  duty_out,
    input  duty_valid,
    input  stuck_high,
    input  sync_err
  );

endinterface : pwm_demod_if

// File: rtl/pwm_sampler.sv
// -----------------------------------------------------------------------------
// pwm_sampler
// Input conditioning for the PWM receiver: 2-FF synchronizer, slot-rate
// prescaler and slot-level edge detection.
//   clk    : receiver clock
//   reset  : asynchronous, active-low reset
//   pwm_i  : raw PWM line
//   tick_o : one-clk pulse, a new slot sample is available in s_o
//   s_o    : current slot sample (valid while tick_o is high, held otherwise)
//   rise_o : s_o high and previous slot sample low
// -----------------------------------------------------------------------------
module pwm_sampler #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic pwm_i,
  output logic tick_o,
  output logic s_o,
  output logic rise_o
);

  localparam int               CNT_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

  logic             sync1_q, sync2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic             s_q, s_d;
  logic             s_prev_q, s_prev_d;

  // The sample is registered together with the tick so the FSM sees the
  // new slot value and the tick in the same cycle.
  always_comb begin
    cnt_d    = cnt_q + CNT_W'(1);
    tick_d   = 1'b0;
    s_d      = s_q;
    s_prev_d = s_prev_q;
    if (cnt_q == CNT_MAX) begin
      cnt_d    = '0;
      tick_d   = 1'b1;
      s_d      = sync2_q;
      s_prev_d = s_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      cnt_q    <= '0;
      tick_q   <= 1'b0;
      s_q      <= 1'b0;
      s_prev_q <= 1'b0;
    end else begin
      sync1_q  <= pwm_i;
      sync2_q  <= sync1_q;
      cnt_q    <= cnt_d;
      tick_q   <= tick_d;
      s_q      <= s_d;
      s_prev_q <= s_prev_d;
    end
  end

  assign tick_o = tick_q;
  assign s_o    = s_q;
  assign rise_o = s_q & ~s_prev_q;

endmodule : pwm_sampler

// File: rtl/pwm_demod.sv
// -----------------------------------------------------------------------------
// pwm_demod
// Audio-path PWM receiver. Locks onto the rising edge that starts each
// FRAME-slot PWM frame, counts high slots and reports the duty value. When
// the line shows no frame structure for 2*FRAME slots it reports the static
// line level (0, or FRAME-1 with stuck_high).
//   CLK_DIV : clk cycles per PWM slot (>= 2)
//   FRAME   : slots per frame, 2**DUTY_W
//   DUTY_W  : duty value width
//   clk     : receiver clock, all logic on its rising edge
//   reset   : asynchronous, active-low reset
//   bus     : pwm_demod_if master (pwm_in, duty_out, duty_valid,
//             stuck_high, sync_err)
// -----------------------------------------------------------------------------
module pwm_demod
  import pwm_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int FRAME   = PWM_FRAME,
  parameter int DUTY_W  = PWM_DUTY_W
) (
  input  logic        clk,
  input  logic        reset,
  pwm_demod_if.master bus
);

  localparam int IDLE_W = $clog2(2 * FRAME + 1);

  localparam logic [DUTY_W-1:0] POS_LAST  = DUTY_W'(FRAME - 1);
  localparam logic [DUTY_W-1:0] POS_PEN   = DUTY_W'(FRAME - 2);
  localparam logic [DUTY_W-1:0] DUTY_MAX  = DUTY_W'(FRAME - 1);
  localparam logic [DUTY_W:0]   HI_FULL   = (DUTY_W + 1)'(FRAME);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(2 * FRAME - 1);

  logic tick, s, rise;

  pwm_sampler #(
    .CLK_DIV (CLK_DIV)
  ) u_sampler (
    .clk    (clk),
    .reset  (reset),
    .pwm_i  (bus.pwm_in),
    .tick_o (tick),
    .s_o    (s),
    .rise_o (rise)
  );

  pwm_state_e        state_q, state_d;
  logic [DUTY_W-1:0] pos_q, pos_d;
  logic [DUTY_W:0]   hi_cnt_q, hi_cnt_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic              valid_q, valid_d;
  logic              stuck_q, stuck_d;
  logic              serr_q, serr_d;

  logic [DUTY_W:0]   hi_acc;

  assign hi_acc = hi_cnt_q + {{DUTY_W{1'b0}}, s};

  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    hi_cnt_d = hi_cnt_q;
    idle_d   = idle_q;
    duty_d   = duty_q;
    stuck_d  = stuck_q;
    valid_d  = 1'b0;
    serr_d   = 1'b0;

    if (tick) begin
      unique case (state_q)
        HUNT: begin
          // A rise always wins over a coincident timeout.
          if (rise) begin
            state_d  = MEASURE;
            pos_d    = '0;
            hi_cnt_d = (DUTY_W + 1)'(1);
            idle_d   = '0;
          end else if (idle_q == IDLE_LAST) begin
            idle_d  = '0;
            valid_d = 1'b1;
            duty_d  = s ? DUTY_MAX : '0;
            stuck_d = s;
          end else begin
            idle_d = idle_q + IDLE_W'(1);
          end
        end

        MEASURE: begin
          if (pos_q == POS_LAST) begin
            // Frame already reported; this tick must carry the next
            // frame's start edge or we have lost the stream.
            if (rise) begin
              pos_d    = '0;
              hi_cnt_d = (DUTY_W + 1)'(1);
            end else begin
              state_d = HUNT;
              idle_d  = IDLE_W'(1);
            end
          end else if (rise) begin
            // Edge inside a frame: resynchronise on it, drop this frame.
            serr_d   = 1'b1;
            pos_d    = '0;
            hi_cnt_d = (DUTY_W + 1)'(1);
          end else begin
            pos_d    = pos_q + DUTY_W'(1);
            hi_cnt_d = hi_acc;
            if (pos_q == POS_PEN) begin
              // Last slot accumulated: report. A full count cannot be
              // represented in DUTY_W bits and means the line never fell.
              valid_d = 1'b1;
              stuck_d = (hi_acc == HI_FULL);
              duty_d  = (hi_acc == HI_FULL) ? DUTY_MAX : hi_acc[DUTY_W-1:0];
            end
          end
        end

        default: begin
          state_d = HUNT;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= HUNT;
      pos_q    <= '0;
      hi_cnt_q <= '0;
      idle_q   <= '0;
      duty_q   <= '0;
      valid_q  <= 1'b0;
      stuck_q  <= 1'b0;
      serr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      hi_cnt_q <= hi_cnt_d;
      idle_q   <= idle_d;
      duty_q   <= duty_d;
      valid_q  <= valid_d;
      stuck_q  <= stuck_d;
      serr_q   <= serr_d;
    end
  end

  assign bus.duty_out   = duty_q;
  assign bus.duty_valid = valid_q;
  assign bus.stuck_high = stuck_q;
  assign bus.sync_err   = serr_q;

endmodule : pwm_demod

// File: tb/tb_pwm_demod.sv
// -----------------------------------------------------------------------------
// tb_pwm_demod
// Directed bench for pwm_demod at CLK_DIV=4 (one slot = 4 clk, one frame =
// 128 clk). The PWM line is driven slot by slot in lock-step with the clock,
// so every slot is sampled exactly once and reports recur at a fixed phase
// relative to frame boundaries.
// -----------------------------------------------------------------------------
module tb_pwm_demod;

  localparam int CLK_DIV = 4;
  localparam int FRAME   = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  pwm_demod_if #(.DUTY_W(5)) bus ();

  pwm_demod #(
    .CLK_DIV (CLK_DIV),
    .FRAME   (FRAME),
    .DUTY_W  (5)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Result monitor: samples 1 time unit after each rising edge.
  int         valid_cnt      = 0;
  int         sync_cnt       = 0;
  int         last_valid_cyc = 0;
  int         prev_valid_cyc = 0;
  logic [4:0] last_duty      = '0;
  logic       last_stuck     = 1'b0;
  logic [4:0] duty_log [0:255];

  always @(posedge clk) begin
    #1;
    if (bus.duty_valid === 1'b1) begin
      duty_log[valid_cnt % 256] = bus.duty_out;
      last_duty      = bus.duty_out;
      last_stuck     = bus.stuck_high;
      prev_valid_cyc = last_valid_cyc;
      last_valid_cyc = cyc;
      valid_cnt++;
      $display("[cyc %0d] duty_valid duty_out=%0d stuck_high=%0d",
               cyc, bus.duty_out, bus.stuck_high);
    end
    if (bus.sync_err === 1'b1) begin
      sync_cnt++;
      $display("[cyc %0d] sync_err", cyc);
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One frame: high for slots < duty, plus an optional extra high slot.
  task automatic drive_frame(input int duty, input int extra_slot);
    for (int sl = 0; sl < FRAME; sl++) begin
      bus.pwm_in = (sl < duty) || (sl == extra_slot);
      repeat (CLK_DIV) @(negedge clk);
    end
  endtask

  int sweep_duty [3] = '{1, 15, 31};
  int base_v;
  int base_s;

  initial begin
    bus.pwm_in = 1'b0;
    rst_n      = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_duty_out",   bus.duty_out,   0);
    chk("rst_duty_valid", bus.duty_valid, 0);
    chk("rst_stuck_high", bus.stuck_high, 0);
    chk("rst_sync_err",   bus.sync_err,   0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Steady duty 10
    base_v = valid_cnt;
    repeat (6) drive_frame(10, -1);
    chk("steady_duty",    last_duty, 10);
    chk("steady_count",   (valid_cnt - base_v) >= 4, 1);
    chk("steady_period",  last_valid_cyc - prev_valid_cyc, FRAME * CLK_DIV);
    chk("steady_stuck",   last_stuck, 0);
    chk("steady_no_serr", sync_cnt, 0);

    // Duty sweep, 3 frames each; the last report in a batch is its own duty
    for (int k = 0; k < 3; k++) begin
      repeat (3) drive_frame(sweep_duty[k], -1);
      chk("sweep_duty",  last_duty,  sweep_duty[k]);
      chk("sweep_stuck", last_stuck, 0);
    end
    chk("sweep_no_serr", sync_cnt, 0);

    // Duty 0: line low, timeout report every 64 ticks
    bus.pwm_in = 1'b0;
    base_v = valid_cnt;
    repeat (900) @(negedge clk);
    chk("zero_count",  (valid_cnt - base_v) >= 3, 1);
    chk("zero_duty",   last_duty, 0);
    chk("zero_stuck",  last_stuck, 0);
    chk("zero_period", last_valid_cyc - prev_valid_cyc, 2 * FRAME * CLK_DIV);

    // Line held high from reset
    bus.pwm_in = 1'b1;
    rst_n      = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (80 * CLK_DIV) @(negedge clk);
    chk("high_stuck", bus.stuck_high, 1);
    chk("high_duty",  bus.duty_out,   31);
    repeat (3) drive_frame(5, -1);
    chk("high_then5_duty",  bus.duty_out,   5);
    chk("high_then5_stuck", bus.stuck_high, 0);

    // Glitch at slot 20 of a duty-8 frame. The glitch restarts the frame at
    // slot 20; the true frame start then lands at pos 12 and realigns with a
    // second sync_err. The glitched frame and the misaligned fragment give no
    // report; window holds the reports of three clean frames.
    repeat (3) drive_frame(8, -1);
    base_v = valid_cnt;
    base_s = sync_cnt;
    drive_frame(8, 20);
    repeat (3) drive_frame(8, -1);
    chk("glitch_serr_cnt",  sync_cnt - base_s, 2);
    chk("glitch_valid_cnt", valid_cnt - base_v, 3);
    for (int i = 0; i < 3; i++)
      chk("glitch_relock_duty", duty_log[(base_v + i) % 256], 8);

    // Reset asserted at slot 12 of a duty-10 frame
    for (int sl = 0; sl < 12; sl++) begin
      bus.pwm_in = (sl < 10);
      repeat (CLK_DIV) @(negedge clk);
    end
    bus.pwm_in = 1'b0;
    chk("pre_reset_duty", bus.duty_out, 8);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_duty",  bus.duty_out,   0);
    chk("async_rst_valid", bus.duty_valid, 0);
    chk("async_rst_stuck", bus.stuck_high, 0);
    chk("async_rst_serr",  bus.sync_err,   0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20 * CLK_DIV) @(negedge clk);
    base_v = valid_cnt;
    repeat (3) drive_frame(10, -1);
    bus.pwm_in = 1'b0;
    repeat (16) @(negedge clk);
    chk("rst_relock_cnt", valid_cnt - base_v, 3);
    for (int i = 0; i < 3; i++)
      chk("rst_relock_duty", duty_log[(base_v + i) % 256], 10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule : tb_pwm_demod
